// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall vector, branch flush, and
// arbitration of the single memory port between instruction fetch and MEM.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_ack,
  output logic [DATA_W-1:0] o_mem_rdata,
  input  logic              i_id_stallreq,
  input  logic              i_ex_stallreq,
  input  logic              i_ex_branch,
  output logic              o_port_req,
  output logic              o_port_we,
  output logic [ADDR_W-1:0] o_port_addr,
  output logic [DATA_W-1:0] o_port_wdata,
  input  logic              i_port_ack,
  input  logic [DATA_W-1:0] i_port_rdata,
  output logic [5:0]        o_stall,
  output logic              o_flush,
  output logic [1:0]        o_state
);

  // Request/ack handshake: a requester raises req and holds it (with stable
  // fields) until it sees a one-cycle ack; port_ack only counts while port_req=1.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IF_BUSY  = 2'd1,
    S_MEM_BUSY = 2'd2,
    S_IF_DROP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_port_req;
  logic                r_port_we;
  logic [ADDR_W-1:0]   r_port_addr;
  logic [DATA_W-1:0]   r_port_wdata;
  logic                w_mem_ack;
  logic                w_if_ack;
  logic                w_s_mem;
  logic                w_s_if;
  logic                w_flush;
  logic                w_load_mem;
  logic                w_load_if;
  logic [5:0]          w_stall;

  assign w_mem_ack = ~i_rst & i_port_ack & (r_state == S_MEM_BUSY);
  assign w_s_mem   = i_mem_req & ~w_mem_ack;
  // A branch behind an EX/MEM stall waits until EX advances.
  assign w_flush   = ~i_rst & i_ex_branch & ~w_s_mem & ~i_ex_stallreq;
  assign w_if_ack  = ~i_rst & i_port_ack & (r_state == S_IF_BUSY) & ~w_flush;
  assign w_s_if    = i_if_req & ~w_if_ack;

  always_comb begin
    w_stall = 6'b000000;
    if (i_rst)              w_stall = 6'b000000;
    else if (w_s_mem)       w_stall = 6'b011111;
    else if (i_ex_stallreq) w_stall = 6'b001111;
    else if (i_id_stallreq) w_stall = 6'b000111;
    else if (w_s_if)        w_stall = 6'b000011;
  end

  always_comb begin
    w_next     = r_state;
    w_load_mem = 1'b0;
    w_load_if  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mem_req) begin
          w_next     = S_MEM_BUSY;
          w_load_mem = 1'b1;
        end else if (i_if_req && !w_flush) begin
          w_next    = S_IF_BUSY;
          w_load_if = 1'b1;
        end
      end
      S_IF_BUSY: begin
        if (i_port_ack)   w_next = S_IDLE;
        else if (w_flush) w_next = S_IF_DROP;
      end
      S_MEM_BUSY: if (i_port_ack) w_next = S_IDLE;
      S_IF_DROP:  if (i_port_ack) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_port_req   <= 1'b0;
      r_port_we    <= 1'b0;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_mem) begin
        r_port_req   <= 1'b1;
        r_port_we    <= i_mem_we;
        r_port_addr  <= i_mem_addr;
        r_port_wdata <= i_mem_wdata;
      end else if (w_load_if) begin
        r_port_req  <= 1'b1;
        r_port_we   <= 1'b0;
        r_port_addr <= i_if_addr;
      end else if (r_state != S_IDLE && i_port_ack) begin
        r_port_req <= 1'b0;
      end
    end
  end

  assign o_if_ack     = w_if_ack;
  assign o_if_rdata   = i_port_rdata;
  assign o_mem_ack    = w_mem_ack;
  assign o_mem_rdata  = i_port_rdata;
  assign o_port_req   = r_port_req;
  assign o_port_we    = r_port_we;
  assign o_port_addr  = r_port_addr;
  assign o_port_wdata = r_port_wdata;
  assign o_stall      = w_stall;
  assign o_flush      = w_flush;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change just after the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_pipe_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IFB  = 2'd1;
  localparam logic [1:0] ST_MEMB = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic        ex_branch;
  logic        port_req;
  logic        port_we;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic        port_ack;
  logic [31:0] port_rdata;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_ack(mem_ack), .o_mem_rdata(mem_rdata),
    .i_id_stallreq(id_stallreq), .i_ex_stallreq(ex_stallreq), .i_ex_branch(ex_branch),
    .o_port_req(port_req), .o_port_we(port_we), .o_port_addr(port_addr), .o_port_wdata(port_wdata),
    .i_port_ack(port_ack), .i_port_rdata(port_rdata),
    .o_stall(stall), .o_flush(flush), .o_state(state)
  );

  // Requesters must hold req until ack (reset cycles exempt).
  logic p_valid = 1'b0, p_if_req, p_if_ack, p_mem_req, p_mem_ack, p_rst;
  always @(posedge clk) begin
    if (p_valid && !rst && !p_rst) begin
      assert (!(p_if_req && !p_if_ack && !if_req)) else $error("protocol violation: if_req dropped before if_ack");
      assert (!(p_mem_req && !p_mem_ack && !mem_req)) else $error("protocol violation: mem_req dropped before mem_ack");
    end
    p_valid   <= 1'b1;
    p_rst     <= rst;
    p_if_req  <= if_req;
    p_if_ack  <= if_ack;
    p_mem_req <= mem_req;
    p_mem_ack <= mem_ack;
  end

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    id_stallreq = 0; ex_stallreq = 0; ex_branch = 0; port_ack = 0; port_rdata = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; if_req = 1; mem_req = 1; ex_branch = 1; port_ack = 1; port_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (stall !== 6'b000000) begin n_errors++; $display("FAIL rst_stall got=%b exp=000000", stall); end
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rst_flush got=%b exp=0", flush); end
    n_checks++; if ({if_ack, mem_ack} !== 2'b00) begin n_errors++; $display("FAIL rst_acks got=%b exp=00", {if_ack, mem_ack}); end
    @(negedge clk);
    #1;
    n_checks++; if ({port_req, port_we, port_addr, port_wdata} !== 66'd0) begin n_errors++; $display("FAIL rst_port got=%b/%b/%h/%h exp=0", port_req, port_we, port_addr, port_wdata); end
    n_checks++; if (state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state got=%0d exp=%0d", state, ST_IDLE); end
    @(negedge clk);
    rst = 0; idle_inputs();
    #1;
    n_checks++; if ({stall, port_req} !== 7'd0) begin n_errors++; $display("FAIL rst_quiet got=%b/%b exp=0", stall, port_req); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk); if_req = 1; if_addr = 32'h100; #1;
    n_checks++; if (stall !== 6'b000011) begin n_errors++; $display("FAIL f_stall0 got=%b exp=000011", stall); end
    n_checks++; if (port_req !== 1'b0) begin n_errors++; $display("FAIL f_req0 got=%b exp=0", port_req); end
    @(negedge clk); #1;
    n_checks++; if ({port_req, port_we, port_addr} !== {1'b1, 1'b0, 32'h100}) begin n_errors++; $display("FAIL f_issue got=%b/%b/%h exp=1/0/00000100", port_req, port_we, port_addr); end
    n_checks++; if (state !== ST_IFB) begin n_errors++; $display("FAIL f_state got=%0d exp=%0d", state, ST_IFB); end
    n_checks++; if ({if_ack, stall} !== {1'b0, 6'b000011}) begin n_errors++; $display("FAIL f_wait1 got=%b/%b exp=0/000011", if_ack, stall); end
    @(negedge clk); #1;
    n_checks++; if ({if_ack, stall} !== {1'b0, 6'b000011}) begin n_errors++; $display("FAIL f_wait2 got=%b/%b exp=0/000011", if_ack, stall); end
    @(negedge clk); port_ack = 1; port_rdata = 32'hDEAD_BEEF; #1;
    n_checks++; if ({if_ack, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL f_ack got=%b/%h exp=1/deadbeef", if_ack, if_rdata); end
    n_checks++; if (stall !== 6'b000000) begin n_errors++; $display("FAIL f_stall_ack got=%b exp=000000", stall); end
    @(negedge clk); port_ack = 0; if_req = 0; #1;
    n_checks++; if ({if_ack, port_req, state} !== {1'b0, 1'b0, ST_IDLE}) begin n_errors++; $display("FAIL f_done got=%b/%b/%0d exp=0/0/0", if_ack, port_req, state); end
  endtask

  task automatic test_contention();
    @(negedge clk); if_req = 1; if_addr = 32'h180; mem_req = 1; mem_we = 0; mem_addr = 32'h2000; #1;
    n_checks++; if (stall !== 6'b011111) begin n_errors++; $display("FAIL c_stall0 got=%b exp=011111", stall); end
    @(negedge clk); #1;
    n_checks++; if ({state, port_req, port_we, port_addr} !== {ST_MEMB, 1'b1, 1'b0, 32'h2000}) begin n_errors++; $display("FAIL c_mem_issue got=%0d/%b/%b/%h exp=2/1/0/00002000", state, port_req, port_we, port_addr); end
    n_checks++; if (stall !== 6'b011111) begin n_errors++; $display("FAIL c_stall1 got=%b exp=011111", stall); end
    @(negedge clk); port_ack = 1; port_rdata = 32'hA5A5_0001; #1;
    n_checks++; if ({mem_ack, if_ack, mem_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin n_errors++; $display("FAIL c_mem_ack got=%b/%b/%h exp=1/0/a5a50001", mem_ack, if_ack, mem_rdata); end
    n_checks++; if (stall !== 6'b000011) begin n_errors++; $display("FAIL c_stall_ack got=%b exp=000011", stall); end
    @(negedge clk); port_ack = 0; mem_req = 0; #1;
    n_checks++; if ({state, port_req, stall} !== {ST_IDLE, 1'b0, 6'b000011}) begin n_errors++; $display("FAIL c_gap got=%0d/%b/%b exp=0/0/000011", state, port_req, stall); end
    @(negedge clk); #1;
    n_checks++; if ({state, port_req, port_addr} !== {ST_IFB, 1'b1, 32'h180}) begin n_errors++; $display("FAIL c_if_issue got=%0d/%b/%h exp=1/1/00000180", state, port_req, port_addr); end
    @(negedge clk); port_ack = 1; port_rdata = 32'h0BAD_F00D; #1;
    n_checks++; if ({if_ack, if_rdata, stall} !== {1'b1, 32'h0BAD_F00D, 6'b000000}) begin n_errors++; $display("FAIL c_if_ack got=%b/%h/%b exp=1/0badf00d/000000", if_ack, if_rdata, stall); end
    @(negedge clk); port_ack = 0; if_req = 0; #1;
    n_checks++; if (port_req !== 1'b0) begin n_errors++; $display("FAIL c_done got=%b exp=0", port_req); end
  endtask

  task automatic test_branch_drop();
    @(negedge clk); if_req = 1; if_addr = 32'h200;
    @(negedge clk); ex_branch = 1; if_addr = 32'h400; #1;
    n_checks++; if ({port_addr, flush} !== {32'h200, 1'b1}) begin n_errors++; $display("FAIL b_flush got=%h/%b exp=00000200/1", port_addr, flush); end
    @(negedge clk); ex_branch = 0; #1;
    n_checks++; if ({state, port_req, port_addr, flush} !== {ST_DROP, 1'b1, 32'h200, 1'b0}) begin n_errors++; $display("FAIL b_drop got=%0d/%b/%h/%b exp=3/1/00000200/0", state, port_req, port_addr, flush); end
    @(negedge clk); port_ack = 1; port_rdata = 32'h1111_1111; #1;
    n_checks++; if ({if_ack, stall} !== {1'b0, 6'b000011}) begin n_errors++; $display("FAIL b_stale got=%b/%b exp=0/000011", if_ack, stall); end
    @(negedge clk); port_ack = 0; #1;
    n_checks++; if ({state, port_req} !== {ST_IDLE, 1'b0}) begin n_errors++; $display("FAIL b_idle got=%0d/%b exp=0/0", state, port_req); end
    @(negedge clk); #1;
    n_checks++; if ({state, port_req, port_addr} !== {ST_IFB, 1'b1, 32'h400}) begin n_errors++; $display("FAIL b_refetch got=%0d/%b/%h exp=1/1/00000400", state, port_req, port_addr); end
    @(negedge clk); port_ack = 1; port_rdata = 32'h2222_2222; #1;
    n_checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h2222_2222}) begin n_errors++; $display("FAIL b_ack got=%b/%h exp=1/22222222", if_ack, if_rdata); end
    @(negedge clk); port_ack = 0; if_req = 0;
  endtask

  task automatic test_priority();
    @(negedge clk); id_stallreq = 1; ex_stallreq = 1; ex_branch = 1; #1;
    n_checks++; if ({stall, flush} !== {6'b001111, 1'b0}) begin n_errors++; $display("FAIL p_ex got=%b/%b exp=001111/0", stall, flush); end
    @(negedge clk); #1;
    n_checks++; if ({stall, flush} !== {6'b001111, 1'b0}) begin n_errors++; $display("FAIL p_hold got=%b/%b exp=001111/0", stall, flush); end
    @(negedge clk); ex_stallreq = 0; #1;
    n_checks++; if ({stall, flush} !== {6'b000111, 1'b1}) begin n_errors++; $display("FAIL p_id got=%b/%b exp=000111/1", stall, flush); end
    @(negedge clk); id_stallreq = 0; ex_branch = 0; #1;
    n_checks++; if ({stall, flush} !== {6'b000000, 1'b0}) begin n_errors++; $display("FAIL p_none got=%b/%b exp=000000/0", stall, flush); end
  endtask

  task automatic test_store();
    @(negedge clk); mem_req = 1; mem_we = 1; mem_addr = 32'h3004; mem_wdata = 32'h1234_5678; ex_branch = 1; #1;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL s_noflush got=%b exp=0", flush); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({port_req, port_we, port_addr, port_wdata, mem_ack, stall} !== {1'b1, 1'b1, 32'h3004, 32'h1234_5678, 1'b0, 6'b011111}) begin
        n_errors++; $display("FAIL s_hold%0d got=%b/%b/%h/%h/%b/%b exp=1/1/00003004/12345678/0/011111", i, port_req, port_we, port_addr, port_wdata, mem_ack, stall);
      end
    end
    @(negedge clk); port_ack = 1; #1;
    n_checks++; if ({mem_ack, stall, flush} !== {1'b1, 6'b000000, 1'b1}) begin n_errors++; $display("FAIL s_ack got=%b/%b/%b exp=1/000000/1", mem_ack, stall, flush); end
    @(negedge clk); port_ack = 0; mem_req = 0; mem_we = 0; ex_branch = 0; #1;
    n_checks++; if ({mem_ack, port_req} !== 2'b00) begin n_errors++; $display("FAIL s_once got=%b/%b exp=0/0", mem_ack, port_req); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); mem_req = 1; mem_addr = 32'h4000;
    @(negedge clk); #1;
    n_checks++; if ({state, port_req} !== {ST_MEMB, 1'b1}) begin n_errors++; $display("FAIL r_busy got=%0d/%b exp=2/1", state, port_req); end
    @(negedge clk); rst = 1; ex_branch = 1; port_ack = 1; #1;
    n_checks++; if ({stall, flush, mem_ack, if_ack} !== 9'd0) begin n_errors++; $display("FAIL r_during got=%b/%b/%b/%b exp=0", stall, flush, mem_ack, if_ack); end
    @(negedge clk); rst = 0; mem_req = 0; ex_branch = 0; #1;
    n_checks++; if ({state, port_req, mem_ack, if_ack} !== {ST_IDLE, 3'b000}) begin n_errors++; $display("FAIL r_late got=%0d/%b/%b/%b exp=0/0/0/0", state, port_req, mem_ack, if_ack); end
    @(negedge clk); port_ack = 0; #1;
    n_checks++; if ({state, port_req} !== {ST_IDLE, 1'b0}) begin n_errors++; $display("FAIL r_settle got=%0d/%b exp=0/0", state, port_req); end
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_single_fetch();
    test_contention();
    test_branch_drop();
    test_priority();
    test_store();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage core. It generates the 6-bit stall vector consumed by every inter-stage register, including the ID/EX register. It also generates the branch flush, and arbitrates the single memory port between instruction fetch (IF) and the MEM stage. Stall bit k freezes stage register k; a register inserts a bubble when stall[k]=1 and stall[k+1]=0. Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  IF wants an instruction word; held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word
mem_req  in  1  MEM-stage access; held until mem_ack
mem_we  in  1  1=store, 0=load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_ack  out  1  one-cycle pulse: access complete
mem_rdata  out  DATA_W  load data
id_stallreq  in  1  load-use hazard from decode
ex_stallreq  in  1  multi-cycle EX operation busy
ex_branch  in  1  taken branch/jump resolved in EX
port_req  out  1  memory port request, registered
port_we  out  1  memory port write enable, registered
port_addr  out  ADDR_W  memory port address, registered
port_wdata  out  DATA_W  memory port write data, registered
port_ack  in  1  memory port completion; valid only while port_req=1
port_rdata  in  DATA_W  read data, valid with port_ack
stall  out  6  stall vector
flush  out  1  squash IF/ID contents this cycle

Behaviour:
- Reset state: FSM in IDLE. port_req=0, port_we=0, port_addr=0, port_wdata=0.
- While rst=1: stall=0, flush=0, if_ack=0, mem_ack=0, regardless of inputs.
- FSM states: IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
- In IDLE:
  - mem_req=1 -> MEM_BUSY. Latch port_we/addr/wdata from mem_*; set port_req=1 next cycle.
  - else if if_req=1 and flush=0 -> IF_BUSY. Latch if_addr; port_we=0; port_req=1 next cycle.
  - else stay in IDLE.
  - MEM has priority over IF.
- In a busy state, port_* outputs are held stable until port_ack. On port_ack: next state IDLE, port_req=0 on the following edge. An IDLE state lasts at least 1 cycle between transactions.
- mem_ack = port_ack when state=MEM_BUSY. if_ack = port_ack when state=IF_BUSY. Otherwise both 0.
- mem_rdata and if_rdata are combinational from port_rdata; don't-care when the corresponding ack=0.
- IF_BUSY with flush=1 -> IF_DROP; the port transaction runs to completion.
- In IF_DROP, port_ack returns to IDLE with if_ack=0; the stale word is discarded.
- If flush=1 and port_ack=1 in the same cycle while in IF_BUSY: if_ack=0, next state IDLE.
- Stall sources (combinational):
  - s_mem = mem_req & ~mem_ack
  - s_if = if_req & ~if_ack
- Stall vector, first match wins:
  - s_mem -> 6'b011111
  - ex_stallreq -> 6'b001111
  - id_stallreq -> 6'b000111
  - s_if -> 6'b000011
  - otherwise 6'b000000
- flush = ex_branch & ~s_mem & ~ex_stallreq. A branch waiting behind an EX/MEM stall is held upstream and flushes on the cycle EX advances.
- Latency:
  - The MEM access issues port_req on the cycle after mem_req is seen in IDLE.
  - If IF is in flight when MEM requests, MEM waits for IF completion, plus 1 IDLE cycle.
- rst asserted mid-transaction: FSM returns to IDLE and port_req drops on that edge. Outstanding port_ack after reset is ignored, since ack only counts while port_req=1.
- A requester must not drop a request before its ack. Dropping one is a protocol violation; the bench flags it with an assertion.

Test Plan:
1. Single fetch: if_req=1, addr=0x100, memory acks 2 cycles after port_req with 0xDEADBEEF -> port_addr=0x100; if_ack pulses 1 cycle with if_rdata=0xDEADBEEF; stall=000011 until that cycle, then 000000.
2. Contention: if_req and mem_req (load, addr=0x2000) both rise in IDLE -> MEM served first; stall=011111 until mem_ack. IF then issues and stall=000011 until if_ack.
3. Branch during fetch: IF_BUSY for addr=0x200, ex_branch=1 for 1 cycle -> flush=1 that cycle; FSM enters IF_DROP; port_ack gives if_ack=0. Next fetch uses the new if_addr=0x400 and completes normally.
4. Priority encoding: id_stallreq=1 and ex_stallreq=1 with no memory activity -> stall=001111. With ex_branch=1 held meanwhile -> flush=0; it goes to 1 on the cycle ex_stallreq drops.
5. Store path: mem_req=1, mem_we=1, addr=0x3004, wdata=0x12345678 -> port_we=1 and fields stable every cycle until port_ack; mem_ack pulses once.
6. Reset mid-transaction: rst=1 while MEM_BUSY -> next cycle port_req=0 and state IDLE. stall=0, flush=0, acks=0 during rst; a late port_ack produces no ack.
